// File: rtl/enemy_bullet_pool_if.sv
// Fire-request channel between the enemy formation logic (master) and the
// enemy bullet pool (slave).
//   fire_req  : one-cycle request to launch a bullet
//   fire_x    : launch center x, valid with fire_req
//   fire_y    : launch top y, valid with fire_req
//   fire_drop : one-cycle pulse from the pool when a request is discarded
interface enemy_bullet_pool_if;
    logic               fire_req;
    logic signed [11:0] fire_x;
    logic signed [11:0] fire_y;
    logic               fire_drop;

    modport master (output fire_req, output fire_x, output fire_y, input fire_drop);
    modport slave  (input fire_req, input fire_x, input fire_y, output fire_drop);
endinterface

// File: rtl/enemy_bullet_pool.sv
// Fixed pool of enemy projectiles moving down the screen.
// Requests are buffered in a one-deep pending register and placed into the
// lowest free slot on the next frame strobe. Every frame, live bullets advance,
// retire at the screen bottom or on contact with the player hitbox, and the
// draw path reports coverage of the current pixel.
// Ports:
//   pixel_clk, rst  : clock, asynchronous active-high reset
//   fsync           : one-cycle frame-boundary strobe
//   clear           : synchronous flush of slots and pending request
//   fire_bus        : fire request channel (slave side), includes fire_drop
//   player_x        : player ship center x
//   hpos, vpos      : current pixel position
//   pixel[0:2]      : RGB888 output, [2]=R [1]=G [0]=B
//   active          : a live bullet covers (hpos, vpos)
//   player_hit      : one-cycle pulse on bullet/player collision
//   live_count      : number of live slots (registered)
module enemy_bullet_pool #(
    parameter int          NUM_SLOTS     = 4,
    parameter int          EBULLET_SPEED = 3,
    parameter int          EBULLET_W     = 4,
    parameter int          EBULLET_H     = 8,
    parameter logic [23:0] EBULLET_COLOR = 24'hFF4020,
    parameter int          VRES          = 600,
    parameter int          PLAYER_W      = 32,
    parameter int          PLAYER_H      = 16
) (
    input  logic                pixel_clk,
    input  logic                rst,
    input  logic                fsync,
    input  logic                clear,
    enemy_bullet_pool_if.slave  fire_bus,
    input  logic signed [11:0]  player_x,
    input  logic signed [11:0]  hpos,
    input  logic signed [11:0]  vpos,
    output logic [7:0]          pixel [0:2],
    output logic                active,
    output logic                player_hit,
    output logic [3:0]          live_count
);

    // 14-bit signed working width so that box edges never wrap.
    localparam logic signed [13:0] SPEED_W = 14'(EBULLET_SPEED);
    localparam logic signed [13:0] HALF_W  = 14'(EBULLET_W / 2);
    localparam logic signed [13:0] BH_W    = 14'(EBULLET_H);
    localparam logic signed [13:0] VRES_W  = 14'(VRES);
    localparam logic signed [13:0] PHALF_W = 14'(PLAYER_W / 2);
    localparam logic signed [13:0] PY_LO   = 14'(VRES - PLAYER_H);
    localparam logic signed [13:0] PY_HI   = 14'(VRES - 1);
    localparam logic [23:0]        COLOR   = EBULLET_COLOR;

    logic [NUM_SLOTS-1:0] live_q, live_d;
    logic signed [11:0]   x_q [NUM_SLOTS];
    logic signed [11:0]   x_d [NUM_SLOTS];
    logic signed [11:0]   y_q [NUM_SLOTS];
    logic signed [11:0]   y_d [NUM_SLOTS];
    logic signed [11:0]   ny  [NUM_SLOTS];

    logic                 pend_q, pend_d;
    logic signed [11:0]   pend_x_q, pend_x_d;
    logic signed [11:0]   pend_y_q, pend_y_d;

    logic                 hit_d, drop_d;
    logic [3:0]           count_d;
    logic [NUM_SLOTS-1:0] off_bottom, hits, covers, free_sel;
    logic                 consume;

    logic signed [13:0]   px_w, hpos_w, vpos_w;

    assign px_w   = {{2{player_x[11]}}, player_x};
    assign hpos_w = {{2{hpos[11]}}, hpos};
    assign vpos_w = {{2{vpos[11]}}, vpos};

    for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
        logic signed [13:0] x_w, y_w, ny_w;

        assign x_w  = {{2{x_q[g][11]}}, x_q[g]};
        assign y_w  = {{2{y_q[g][11]}}, y_q[g]};
        assign ny_w = y_w + SPEED_W;
        assign ny[g] = ny_w[11:0];

        assign off_bottom[g] = (ny_w >= VRES_W);
        // Box at the advanced position against the player hitbox, inclusive edges.
        assign hits[g] = (x_w + HALF_W >= px_w - PHALF_W) &&
                         (x_w - HALF_W <= px_w + PHALF_W) &&
                         (ny_w + BH_W >= PY_LO) &&
                         (ny_w <= PY_HI);
        assign covers[g] = live_q[g] &&
                           (x_w - HALF_W <= hpos_w) && (hpos_w <= x_w + HALF_W) &&
                           (y_w <= vpos_w) && (vpos_w <= y_w + BH_W);
    end

    // One-hot lowest dead slot, taken from the pre-frame live bits so that
    // slots retired this frame are not reused until the next one.
    always_comb begin
        logic found;
        found    = 1'b0;
        free_sel = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            free_sel[i] = !live_q[i] && !found;
            found       = found || !live_q[i];
        end
    end

    assign consume = fsync && pend_q && (|free_sel);

    always_comb begin
        live_d   = live_q;
        x_d      = x_q;
        y_d      = y_q;
        pend_d   = pend_q;
        pend_x_d = pend_x_q;
        pend_y_d = pend_y_q;
        hit_d    = 1'b0;
        drop_d   = 1'b0;
        count_d  = '0;

        if (fsync) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (live_q[i]) begin
                    if (off_bottom[i]) begin
                        live_d[i] = 1'b0;
                    end else if (hits[i]) begin
                        live_d[i] = 1'b0;
                        hit_d     = 1'b1;
                    end else begin
                        y_d[i] = ny[i];
                    end
                end
            end
            if (consume) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (free_sel[i]) begin
                        live_d[i] = 1'b1;
                        x_d[i]    = pend_x_q;
                        y_d[i]    = pend_y_q;
                    end
                end
                pend_d = 1'b0;
            end
        end

        // A frame that empties the pending register frees it for a same-cycle request.
        if (fire_bus.fire_req) begin
            if (!pend_q || consume) begin
                pend_d   = 1'b1;
                pend_x_d = fire_bus.fire_x;
                pend_y_d = fire_bus.fire_y;
            end else begin
                drop_d = 1'b1;
            end
        end

        if (clear) begin
            live_d = '0;
            pend_d = 1'b0;
            hit_d  = 1'b0;
            drop_d = 1'b0;
        end

        for (int i = 0; i < NUM_SLOTS; i++) begin
            count_d = count_d + 4'(live_d[i]);
        end
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            live_q    <= '0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
            pend_q             <= 1'b0;
            pend_x_q           <= '0;
            pend_y_q           <= '0;
            player_hit         <= 1'b0;
            fire_bus.fire_drop <= 1'b0;
            live_count         <= '0;
        end else begin
            live_q             <= live_d;
            x_q                <= x_d;
            y_q                <= y_d;
            pend_q             <= pend_d;
            pend_x_q           <= pend_x_d;
            pend_y_q           <= pend_y_d;
            player_hit         <= hit_d;
            fire_bus.fire_drop <= drop_d;
            live_count         <= count_d;
        end
    end

    assign active = |covers;

    always_comb begin
        pixel[2] = active ? COLOR[23:16] : 8'h00;
        pixel[1] = active ? COLOR[15:8]  : 8'h00;
        pixel[0] = active ? COLOR[7:0]   : 8'h00;
    end

endmodule

// File: doc/enemy_bullet_pool.md
Name: enemy_bullet_pool

Overview:
Manages a fixed pool of enemy projectiles that travel downward toward the player ship. Enemy/formation logic issues fire requests. The pool allocates slots, advances every live bullet once per frame on fsync, retires bullets at the screen bottom or on contact with the player hitbox, and pulses player_hit. It also drives per-pixel RGB and active outputs for the video mixer, alongside the player bullet and ship layers.

Parameters:
NUM_SLOTS, 4, number of simultaneous enemy bullets (1..8)
EBULLET_SPEED, 3, pixels moved downward per frame
EBULLET_W, 4, bullet width in pixels (even); x extent is center ±W/2
EBULLET_H, 8, bullet height in pixels; y extent is top..top+H
EBULLET_COLOR, 24'hFF4020, RGB888 draw colour
VRES, 600, visible lines
PLAYER_W, 32, player hitbox width (even), centered on player_x
PLAYER_H, 16, player hitbox height; hitbox rows VRES-PLAYER_H..VRES-1

Ports:
pixel_clk  in  1  pixel clock
rst  in  1  asynchronous active-high reset
fsync  in  1  one-cycle frame-boundary strobe
clear  in  1  synchronous flush of all slots and the pending request (level restart)
fire_req  in  1  one-cycle request to launch a bullet
fire_x  in  12 signed  launch center x, sampled with fire_req
fire_y  in  12 signed  launch top y, sampled with fire_req
player_x  in  12 signed  player ship center x
hpos  in  12 signed  current pixel x
vpos  in  12 signed  current pixel y
pixel  out  [7:0] x3 unpacked [0:2]  RGB output; [2]=R, [1]=G, [0]=B
active  out  1  a live bullet covers (hpos,vpos)
player_hit  out  1  one-cycle pulse on a bullet/player collision
fire_drop  out  1  one-cycle pulse when a request is discarded
live_count  out  4  number of live slots

Behaviour:
- Reset (async, rst=1): all slots dead; slot x/y=0; pending empty; player_hit=0; fire_drop=0; live_count=0.
- Per slot: live bit, x (12b signed), y (12b signed). All arithmetic is 12-bit signed. Compute comparisons without truncation.
- Pending register (1-deep):
  - fire_req with pending empty: capture fire_x/fire_y next cycle; pending=1.
  - fire_req with pending full: discard request; fire_drop=1 for one cycle.
  - fire_req in the same cycle as an fsync that consumes pending: the new request is captured into pending (consume-then-refill); no drop.
- On fsync (state updates visible the cycle after fsync):
  1. Every live slot: ny = y + EBULLET_SPEED.
     - If ny >= VRES, slot dies.
     - Else if the bullet box at ny overlaps the player hitbox (inclusive ranges, both axes), slot dies and player_hit=1 for exactly one cycle. Multiple hits in one frame produce one pulse.
     - Otherwise y <= ny.
  2. If pending: allocate to the lowest-index slot that was dead before this fsync. Slots freed in step 1 are not reusable until the next fsync. Allocated slot: live=1, x/y = pending values; pending clears.
     - If no slot is free, pending is held until a later fsync; it is not dropped.
  3. A bullet allocated on this fsync does not move or collide until the next fsync.
- clear=1: all slots die, pending empties, no player_hit or fire_drop. clear overrides fsync and fire_req in the same cycle.
- live_count is registered and equals the popcount of live bits, updated the same cycle as the slot bits.
- Draw path (combinational from hpos/vpos and slot registers):
  - active = OR over live slots of (x-W/2 <= hpos <= x+W/2) && (y <= vpos <= y+H).
  - pixel = EBULLET_COLOR when active, else 0.
- Slot state changes only on fsync or clear, so the image is stable within a frame.

Test Plan:
- Reset then a single fire_req (x=400, y=100), then one fsync -> slot0 live, live_count=1, active=1 at (400,104), active=0 at (403,104). After a second fsync -> y=103.
- 5 fire_req pulses, each followed by an fsync, with player_x far away -> slots 0..3 fill. The 5th request stays pending with no drop. A 6th fire_req before the next fsync -> fire_drop pulses once.
- Bullet at y=590, fsync -> ny=593, 593+8 >= VRES, but a bullet at y=598 gives ny=601 >= 600 -> slot dies, live_count decrements, no player_hit.
- Bullet x=300, y=575, player_x=310, fsync -> ny=578, box overlaps rows 584..599 -> player_hit single pulse, slot dies. Repeat with player_x=340 (x 324..356 vs 298..302) -> no hit.
- Two bullets colliding on the same fsync -> exactly one player_hit pulse; live_count drops by 2.
- clear asserted together with fsync and fire_req while 3 slots are live -> live_count=0, pending empty, no pulses. Async rst mid-frame -> all outputs 0 immediately.
